// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between fetch and decode; optional bypass via FETCH_QUEUE_BYPASS_EN
// decode_require packs {pc[96:65], inst[64:33], predict_pc_addr[32:1], predict_brunch_taken[0]}.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      fetch_valid,
   input  logic [31:0]               fetch_pc,
   input  logic [31:0]               fetch_inst,
   input  logic [31:0]               fetch_predict_pc_addr,
   input  logic                      fetch_predict_brunch_taken,
   output logic                      fetch_ready,
   output logic [96:0]               decode_require,
   output logic                      decode_valid,
   input  logic                      decode_ready,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 97;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [EW-1:0] fetch_entry;
   logic          push, pop, bypass;

   assign fetch_entry = {fetch_pc, fetch_inst, fetch_predict_pc_addr, fetch_predict_brunch_taken};
   assign fetch_ready = (count_q != FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue with a willing decoder: hand the offer straight through, never store it.
   assign bypass = (count_q == '0) && fetch_valid && decode_ready && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign decode_valid   = (count_q != '0) || bypass;
   assign decode_require = bypass ? fetch_entry : mem_q[head_q];
   assign push  = fetch_valid && fetch_ready && !flush && !bypass;
   assign pop   = (count_q != '0) && decode_ready && !flush;
   assign count = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + AW'(1);
         if (pop)  head_d = head_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage is only cleared by reset; flush just rewinds the pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push) mem_q[tail_q] <= fetch_entry;
      end
   end
endmodule
